bf_input_commutator: RTL

//  Upstream feeder for one radix-2 butterfly stage in the streaming FFT pipeline.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/bf_input_commutator_if.sv | 40 ++++
 rtl/bf_input_commutator_buf.sv | 46 ++++
 rtl/bf_input_commutator.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT pipeline stages
// (input commutator, butterfly, twiddle ROM).
//   FFT_WIDTH  default component width of a complex sample
//   cplx_t     complex sample {re, im}, two's complement
//   phase_e    commutator block phase: first half buffered, second half paired
//   idx_width  $clog2 floored at 1, used for index and address widths
package fft_pkg;

  localparam int unsigned FFT_WIDTH = 16;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    PH_FILL,
    PH_PAIR
  } phase_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bf_input_commutator_if.sv
// Sample-in / pair-out bus of the butterfly input commutator.
//   master : upstream producer (drives in_*, observes pair outputs)
//   slave  : the commutator itself
// Signals:
//   in_valid, in_sof, in_re, in_im      incoming sample and block start marker
//   out_valid, a_re, a_im, b_re, b_im   registered butterfly operand pair
//   tw_idx                              twiddle ROM address for the pair
//   sync_err                            one-cycle pulse on a mid-block in_sof
interface bf_input_commutator_if
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  logic             in_valid;
  logic             in_sof;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             out_valid;
  logic [WIDTH-1:0] a_re;
  logic [WIDTH-1:0] a_im;
  logic [WIDTH-1:0] b_re;
  logic [WIDTH-1:0] b_im;
  logic [IDX_W-1:0] tw_idx;
  logic             sync_err;

  modport master (
    output in_valid, in_sof, in_re, in_im,
    input  out_valid, a_re, a_im, b_re, b_im, tw_idx, sync_err
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_im,
    output out_valid, a_re, a_im, b_re, b_im, tw_idx, sync_err
  );

endinterface

// File: rtl/bf_input_commutator_buf.sv
// commutator_buf: DEPTH x 2*WIDTH sample store for the first half of a block.
// Single write port (clocked), single asynchronous read port.
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  {re, im} sample to store
//   raddr  read address
//   rdata  {re, im} stored sample at raddr (combinational)
// Contents are not reset.
module commutator_buf
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [idx_width(DEPTH)-1:0]   waddr,
  input  logic [2*WIDTH-1:0]            wdata,
  input  logic [idx_width(DEPTH)-1:0]   raddr,
  output logic [2*WIDTH-1:0]            rdata
);

  if (DEPTH == 1) begin : g_reg
    // A single entry needs no addressing.
    logic [2*WIDTH-1:0] q;
    logic               addr_unused;

    assign addr_unused = ^{waddr, raddr};

    always_ff @(posedge clk) begin
      if (we) q <= wdata;
    end

    assign rdata = q;
  end else begin : g_mem
    logic [2*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/bf_input_commutator.sv
// bf_input_commutator: feeds one radix-2 butterfly stage.
// Buffers samples 0..DEPTH-1 of each 2*DEPTH block, then pairs each
// second-half sample x[k+DEPTH] with its stored partner x[k] and emits
// {a=x[k], b=x[k+DEPTH], tw_idx=k} one clock after the second-half sample.
// No backpressure; in_valid gaps simply hold the sample index.
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       bf_input_commutator_if.slave (samples in, pairs out, sync_err)
// Build option COMMUTATOR_SOF_CHECK_EN: a mid-block in_sof realigns the block
// to that sample (index 0) and pulses sync_err; when undefined in_sof is
// ignored and sync_err is tied 0.
module bf_input_commutator
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bf_input_commutator_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = idx_width(2 * DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
  } sample_t;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  phase_e           phase;
  logic             resync;
  logic             buf_we;
  logic [IDX_W-1:0] wr_addr;
  logic [IDX_W-1:0] pair_k;
  sample_t          in_s;
  sample_t          rd_s;

  logic             out_valid_q;
  sample_t          a_q;
  sample_t          b_q;
  logic [IDX_W-1:0] tw_q;

  assign in_s = {bus.in_re, bus.in_im};

`ifdef COMMUTATOR_SOF_CHECK_EN
  logic sync_err_q;

  assign resync = bus.in_valid & bus.in_sof & (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) sync_err_q <= 1'b0;
    else     sync_err_q <= resync;
  end

  assign bus.sync_err = sync_err_q;
`else
  logic sof_unused;

  assign sof_unused   = bus.in_sof;
  assign resync       = 1'b0;
  assign bus.sync_err = 1'b0;
`endif

  // Sample index register.
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  // Next index: a realigning sample is index 0, so the following one is 1.
  always_comb begin
    cnt_nxt = cnt;
    if (bus.in_valid) begin
      if (resync)                cnt_nxt = CNT_W'(1);
      else if (cnt == CNT_LAST)  cnt_nxt = '0;
      else                       cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Phase decode and buffer control. Writes happen only in FILL and reads
  // only in PAIR, so the async read never needs a write bypass.
  always_comb begin
    phase   = (cnt >= CNT_HALF) ? PH_PAIR : PH_FILL;
    pair_k  = IDX_W'(cnt - CNT_HALF);
    wr_addr = resync ? '0 : IDX_W'(cnt);
    buf_we  = bus.in_valid & (resync | (phase == PH_FILL));
  end

  commutator_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_addr),
    .wdata (in_s),
    .raddr (pair_k),
    .rdata (rd_s)
  );

  // Pair output registers; data and index hold when no pair is formed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tw_q        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.in_valid && !resync && (phase == PH_PAIR)) begin
        out_valid_q <= 1'b1;
        a_q         <= rd_s;
        b_q         <= in_s;
        tw_q        <= pair_k;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.a_re      = a_q.re;
  assign bus.a_im      = a_q.im;
  assign bus.b_re      = b_q.re;
  assign bus.b_im      = b_q.im;
  assign bus.tw_idx    = tw_q;

endmodule
